trail_collision_reader: RTL and testbench

- Read-side counterpart of the trail writer. Once per frame during play, reads the trail-occupancy map at each bike's new grid cell and flags collisions with a trail, a wall, or the other bike.
- Sits between the bike motion logic (X/Y inputs) and the game-state FSM (collision outputs), on the read port of the trail map RAM.
- Trail map codes: 0 empty, 1 B_HORIZ, 2 B_VERT, 3 R_HORIZ, 4 R_VERT, 5 CORNER. Any nonzero code is occupied.

---
 rtl/trail_pkg.sv | 32 +++
 rtl/frame_edge_sync.sv | 28 ++
 rtl/trail_collision_reader.sv | 155 +++++++++++++++
 tb/tb_trail_collision_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trail_pkg.sv
// Shared definitions for the trail map writer/reader pair: grid geometry,
// trail cell codes and the collision reader's state encoding.
package trail_pkg;

    localparam int GRID_W = 112;
    localparam int GRID_H = 112;

    localparam logic [2:0] PLAYING = 3'b010;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        B_HORIZ = 3'd1,
        B_VERT  = 3'd2,
        R_HORIZ = 3'd3,
        R_VERT  = 3'd4,
        CORNER  = 3'd5
    } trail_code_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ_B,
        WAIT_B,
        REQ_R,
        WAIT_R,
        RESOLVE
    } reader_state_t;

    function automatic logic in_bounds(input logic [7:0] x, input logic [7:0] y);
        return (x < 8'(GRID_W)) && (y < 8'(GRID_H));
    endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Brings the asynchronous frame strobe into the system clock domain and
// emits a one-cycle pulse on each rising edge.
module frame_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/trail_collision_reader.sv
// Once per frame, reads the trail map at each bike's new cell and raises
// sticky collision flags for trail hits, wall hits and head-on crashes.
module trail_collision_reader
    import trail_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [2:0]        Game_State,
    input  logic [7:0]        Blue_X,
    input  logic [7:0]        Blue_Y,
    input  logic [7:0]        Red_X,
    input  logic [7:0]        Red_Y,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic              collision_blue,
    output logic              collision_red,
    output logic              check_done
);

    localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

    reader_state_t state;
    logic [1:0]    wait_cnt;
    logic          frame_edge;

    logic [7:0] bx, by, rx, ry;
    logic [7:0] last_bx, last_by, last_rx, last_ry;
    logic       wall_b, wall_r, headon;
    logic       read_b, read_r;
    logic       hit_b;

    logic              blue_go;
    logic              red_go;
    logic              hit_r;
    logic              data_occupied;
    logic [ADDR_W-1:0] blue_cell;
    logic [ADDR_W-1:0] red_cell;

    frame_edge_sync u_frame_edge_sync (
        .clk      (Clk),
        .reset    (Reset),
        .async_in (frame_clk),
        .rise     (frame_edge)
    );

    // Blue is judged from the live inputs because its read is issued in the
    // same cycle the coordinates are captured; red uses the captured copy.
    assign blue_go = in_bounds(Blue_X, Blue_Y) && ((Blue_X != last_bx) || (Blue_Y != last_by));
    assign red_go  = in_bounds(rx, ry) && ((rx != last_rx) || (ry != last_ry));

    assign blue_cell = ADDR_W'(Blue_Y) * ADDR_W'(GRID_W) + ADDR_W'(Blue_X);
    assign red_cell  = ADDR_W'(ry) * ADDR_W'(GRID_W) + ADDR_W'(rx);

    assign data_occupied = (trail_code_t'(rd_data) != EMPTY);
    assign hit_r         = data_occupied && read_r;

    always_ff @(posedge Clk) begin
        if (Reset || (Game_State != PLAYING)) begin
            state          <= IDLE;
            wait_cnt       <= 2'd0;
            rd_en          <= 1'b0;
            rd_addr        <= '0;
            collision_blue <= 1'b0;
            collision_red  <= 1'b0;
            check_done     <= 1'b0;
            bx             <= 8'h00;
            by             <= 8'h00;
            rx             <= 8'h00;
            ry             <= 8'h00;
            last_bx        <= 8'hFF;
            last_by        <= 8'hFF;
            last_rx        <= 8'hFF;
            last_ry        <= 8'hFF;
            wall_b         <= 1'b0;
            wall_r         <= 1'b0;
            headon         <= 1'b0;
            read_b         <= 1'b0;
            read_r         <= 1'b0;
            hit_b          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    check_done <= 1'b0;
                    if (frame_edge) begin
                        bx     <= Blue_X;
                        by     <= Blue_Y;
                        rx     <= Red_X;
                        ry     <= Red_Y;
                        wall_b <= !in_bounds(Blue_X, Blue_Y);
                        wall_r <= !in_bounds(Red_X, Red_Y);
                        headon <= (Blue_X == Red_X) && (Blue_Y == Red_Y);
                        read_b <= blue_go;
                        if (blue_go) begin
                            rd_en   <= 1'b1;
                            rd_addr <= blue_cell;
                        end
                        state <= REQ_B;
                    end
                end
                REQ_B: begin
                    rd_en    <= 1'b0;
                    wait_cnt <= 2'd0;
                    state    <= WAIT_B;
                end
                WAIT_B: begin
                    if (wait_cnt == LAST_WAIT) begin
                        hit_b  <= data_occupied && read_b;
                        read_r <= red_go;
                        if (red_go) begin
                            rd_en   <= 1'b1;
                            rd_addr <= red_cell;
                        end
                        state <= REQ_R;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                REQ_R: begin
                    rd_en    <= 1'b0;
                    wait_cnt <= 2'd0;
                    state    <= WAIT_R;
                end
                WAIT_R: begin
                    // Flags and the done pulse are registered here so they are
                    // visible together during the RESOLVE cycle.
                    if (wait_cnt == LAST_WAIT) begin
                        collision_blue <= collision_blue | hit_b | wall_b | headon;
                        collision_red  <= collision_red | hit_r | wall_r | headon;
                        check_done     <= 1'b1;
                        state          <= RESOLVE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RESOLVE: begin
                    check_done <= 1'b0;
                    last_bx    <= bx;
                    last_by    <= by;
                    last_rx    <= rx;
                    last_ry    <= ry;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trail_collision_reader.sv
// Drives two readers (read latency 1 and 3) from one stimulus stream and
// compares them against a frame-level reference model of the collision rules.
module tb_trail_collision_reader;

    localparam logic [2:0] PLAY = 3'b010;
    localparam int GW = 112;
    localparam int GH = 112;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset;
    logic       frame_clk;
    logic [2:0] game_state;
    logic [7:0] blue_x, blue_y, red_x, red_y;

    logic        rd_en1, rd_en3;
    logic [13:0] rd_addr1, rd_addr3;
    logic [2:0]  rd_data1, rd_data3;
    logic        cb1, cr1, cd1, cb3, cr3, cd3;

    trail_collision_reader #(.ADDR_W(14), .RD_LAT(1)) dut1 (
        .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .Game_State(game_state),
        .Blue_X(blue_x), .Blue_Y(blue_y), .Red_X(red_x), .Red_Y(red_y),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .collision_blue(cb1), .collision_red(cr1), .check_done(cd1)
    );

    trail_collision_reader #(.ADDR_W(14), .RD_LAT(3)) dut3 (
        .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .Game_State(game_state),
        .Blue_X(blue_x), .Blue_Y(blue_y), .Red_X(red_x), .Red_Y(red_y),
        .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .collision_blue(cb3), .collision_red(cr3), .check_done(cd3)
    );

    // Trail map RAM model; outside a valid read slot it returns nonzero junk.
    logic [2:0]  trail_map [0:16383];
    logic        en1_p = 1'b0;
    logic [13:0] a1_p = '0;
    logic [2:0]  en3_p = '0;
    logic [13:0] a3_p [0:2];
    logic [2:0]  junk1 = 3'd7;
    logic [2:0]  junk3 = 3'd7;

    always @(posedge clk) begin
        en1_p   <= rd_en1;
        a1_p    <= rd_addr1;
        en3_p   <= {en3_p[1:0], rd_en3};
        a3_p[0] <= rd_addr3;
        a3_p[1] <= a3_p[0];
        a3_p[2] <= a3_p[1];
        junk1   <= 3'($urandom_range(1, 7));
        junk3   <= 3'($urandom_range(1, 7));
    end

    assign rd_data1 = en1_p ? trail_map[a1_p] : junk1;
    assign rd_data3 = en3_p[2] ? trail_map[a3_p[2]] : junk3;

    int q1[$];
    int q3[$];

    always @(negedge clk) begin
        if (rd_en1 === 1'b1) q1.push_back(int'(rd_addr1));
        if (rd_en3 === 1'b1) q3.push_back(int'(rd_addr3));
    end

    int total = 0;
    int bad = 0;

    int m_lbx, m_lby, m_lrx, m_lry;
    bit m_fb, m_fr;
    int m_last_addr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_lbx = 255; m_lby = 255; m_lrx = 255; m_lry = 255;
        m_fb = 1'b0; m_fr = 1'b0;
        m_last_addr = 0;
    endtask

    task automatic gameRestart();
        @(negedge clk);
        game_state = 3'b000;
        repeat (2) @(negedge clk);
        game_state = PLAY;
        modelReset();
        @(negedge clk);
        checkOutput("restart_blue1", cb1, 0);
        checkOutput("restart_red3", cr3, 0);
    endtask

    // One frame: strobe frame_clk, watch both readers, then score against the model.
    task automatic applyStimulus(input int bx, input int by, input int rx, input int ry, input bit glitch);
        int exp_q[$];
        int lat1, lat3, n1, n3;
        logic sb1, sr1, sb3, sr3;
        bit wb, wr, mb, mr, head, hb, hr;
        @(negedge clk);
        blue_x = 8'(bx); blue_y = 8'(by); red_x = 8'(rx); red_y = 8'(ry);
        q1.delete(); q3.delete();
        lat1 = -1; lat3 = -1; n1 = 0; n3 = 0;
        sb1 = 1'b0; sr1 = 1'b0; sb3 = 1'b0; sr3 = 1'b0;
        frame_clk = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (cd1 === 1'b1) begin
                n1++;
                if (lat1 < 0) begin lat1 = c; sb1 = cb1; sr1 = cr1; end
            end
            if (cd3 === 1'b1) begin
                n3++;
                if (lat3 < 0) begin lat3 = c; sb3 = cb3; sr3 = cr3; end
            end
            if (glitch && c == 2) frame_clk = 1'b0;
            if (glitch && c == 3) frame_clk = 1'b1;
        end
        frame_clk = 1'b0;
        repeat (3) @(negedge clk);

        wb = (bx >= GW) || (by >= GH);
        wr = (rx >= GW) || (ry >= GH);
        mb = (bx != m_lbx) || (by != m_lby);
        mr = (rx != m_lrx) || (ry != m_lry);
        head = (bx == rx) && (by == ry);
        hb = 1'b0; hr = 1'b0;
        if (!wb && mb) begin
            exp_q.push_back(by * GW + bx);
            hb = (trail_map[by * GW + bx] != 3'd0);
        end
        if (!wr && mr) begin
            exp_q.push_back(ry * GW + rx);
            hr = (trail_map[ry * GW + rx] != 3'd0);
        end
        m_fb = m_fb | hb | wb | head;
        m_fr = m_fr | hr | wr | head;
        m_lbx = bx; m_lby = by; m_lrx = rx; m_lry = ry;
        if (exp_q.size() > 0) m_last_addr = exp_q[exp_q.size() - 1];

        checkOutput("done_latency_lat1", lat1, 7);
        checkOutput("done_latency_lat3", lat3, 11);
        checkOutput("done_count_lat1", n1, 1);
        checkOutput("done_count_lat3", n3, 1);
        checkOutput("blue_flag_lat1", sb1, m_fb);
        checkOutput("red_flag_lat1", sr1, m_fr);
        checkOutput("blue_flag_lat3", sb3, m_fb);
        checkOutput("red_flag_lat3", sr3, m_fr);
        checkOutput("read_count_lat1", q1.size(), exp_q.size());
        checkOutput("read_count_lat3", q3.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q1.size()) checkOutput("read_addr_lat1", q1[i], exp_q[i]);
            if (i < q3.size()) checkOutput("read_addr_lat3", q3[i], exp_q[i]);
        end
        checkOutput("addr_hold_lat1", rd_addr1, m_last_addr);
        checkOutput("addr_hold_lat3", rd_addr3, m_last_addr);
    endtask

    function automatic logic [15:0] pick_pos(input int lx, input int ly);
        int r, x, y;
        r = int'($urandom_range(0, 9));
        x = lx;
        y = ly;
        if (lx >= GW || ly >= GH || r == 0) begin
            x = int'($urandom_range(0, GW - 1));
            y = int'($urandom_range(0, GH - 1));
        end else if (r == 2) begin
            x = int'($urandom_range(GW, 255));
            y = int'($urandom_range(0, 255));
        end else if (r > 2) begin
            case ($urandom_range(0, 3))
                0: x = x + 1;
                1: x = x - 1;
                2: y = y + 1;
                default: y = y - 1;
            endcase
        end
        return {8'(x), 8'(y)};
    endfunction

    initial begin
        logic [15:0] pb, pr;
        int nd;
        for (int i = 0; i < 16384; i++) trail_map[i] = 3'd0;
        reset = 1'b1;
        frame_clk = 1'b0;
        game_state = PLAY;
        blue_x = 8'd0; blue_y = 8'd0; red_x = 8'd0; red_y = 8'd0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_rd_en", rd_en1, 0);
        checkOutput("reset_rd_addr", rd_addr1, 0);
        checkOutput("reset_blue", cb1, 0);
        checkOutput("reset_red", cr3, 0);
        checkOutput("reset_done", cd3, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] empty map, both bikes moving");
        applyStimulus(10, 10, 50, 50, 0);
        applyStimulus(11, 10, 50, 51, 0);

        $display("[TB] red runs into a trail, flag stays sticky");
        gameRestart();
        trail_map[51 * GW + 50] = 3'd4;
        applyStimulus(10, 10, 50, 50, 0);
        applyStimulus(11, 10, 50, 51, 0);
        applyStimulus(12, 10, 50, 52, 0);
        applyStimulus(13, 10, 50, 53, 0);
        applyStimulus(14, 10, 50, 54, 0);

        $display("[TB] wall hits");
        gameRestart();
        applyStimulus(112, 5, 40, 40, 0);
        gameRestart();
        applyStimulus(5, 255, 40, 40, 0);

        $display("[TB] head-on");
        gameRestart();
        applyStimulus(30, 30, 30, 30, 0);

        $display("[TB] leave play during WAIT_B");
        @(negedge clk);
        frame_clk = 1'b1;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        game_state = 3'b000;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_rd_en1", rd_en1, 0);
        checkOutput("abort_rd_en3", rd_en3, 0);
        checkOutput("abort_blue1", cb1, 0);
        checkOutput("abort_red1", cr1, 0);
        checkOutput("abort_blue3", cb3, 0);
        checkOutput("abort_red3", cr3, 0);
        nd = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (cd1 === 1'b1 || cd3 === 1'b1) nd++;
        end
        checkOutput("abort_no_done", nd, 0);
        frame_clk = 1'b0;
        game_state = PLAY;
        modelReset();
        repeat (3) @(negedge clk);

        $display("[TB] unmoved blue on its own trail");
        applyStimulus(20, 20, 60, 60, 0);
        trail_map[20 * GW + 20] = 3'd1;
        applyStimulus(20, 20, 61, 60, 0);

        $display("[TB] extra frame edge mid-check");
        applyStimulus(21, 20, 62, 60, 1);

        $display("[TB] random frames");
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) == 0) gameRestart();
            pb = pick_pos(m_lbx, m_lby);
            pr = pick_pos(m_lrx, m_lry);
            if ($urandom_range(0, 9) == 0) pr = pb;
            if (pb[15:8] < 8'(GW) && pb[7:0] < 8'(GH) && $urandom_range(0, 2) == 0)
                trail_map[int'(pb[7:0]) * GW + int'(pb[15:8])] = 3'($urandom_range(0, 5));
            if (pr[15:8] < 8'(GW) && pr[7:0] < 8'(GH) && $urandom_range(0, 2) == 0)
                trail_map[int'(pr[7:0]) * GW + int'(pr[15:8])] = 3'($urandom_range(0, 5));
            applyStimulus(int'(pb[15:8]), int'(pb[7:0]), int'(pr[15:8]), int'(pr[7:0]), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
